// File: rtl/memctrl_responder.sv
// memctrl_responder: answers decoded peripheral requests with WAIT, performs the memory access,
// then replies READY with data, or RETRANSMIT on a corrupt request or memory timeout.
module memctrl_responder #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iRxFlag,
    input  logic        iRead,
    input  logic        iWrite,
    input  logic [23:0] iAddr,
    input  logic [31:0] iData,
    input  logic        iError,
    input  logic        iTxDone,
    output logic        oTransmit,
    output logic [95:0] oOutputMsg,
    output logic        oMemReq,
    output logic        oMemWe,
    output logic [23:0] oMemAddr,
    output logic [31:0] oMemWData,
    input  logic        iMemAck,
    input  logic [31:0] iMemRData,
    output logic        oBusy,
    output logic        oOverrun,
    output logic [7:0]  oRetryCount
);
    typedef enum logic [2:0] {
        IDLE, TX_WAIT, DONE_WAIT, MEM, TX_READY, DONE_READY, TX_RETRY, DONE_RETRY
    } state_t;

    state_t     state;
    logic       isRead;
    logic [7:0] memCnt;
    logic       reqBad;
    logic [7:0] retryNext;

    function automatic logic [95:0] mkMsg(input logic [15:0] hdr, input logic [31:0] data,
                                          input logic [23:0] addr, input logic [7:0] err);
        return {8'h0F, hdr, data, addr, err, 8'hF0};
    endfunction

    assign reqBad    = iError | (iRead == iWrite);
    assign retryNext = (oRetryCount == 8'hFF) ? oRetryCount : oRetryCount + 8'd1;
    assign oBusy     = state != IDLE;
    assign oMemWe    = oMemReq & ~isRead;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            isRead      <= 1'b0;
            memCnt      <= 8'd0;
            oTransmit   <= 1'b0;
            oOutputMsg  <= 96'd0;
            oMemReq     <= 1'b0;
            oMemAddr    <= 24'd0;
            oMemWData   <= 32'd0;
            oOverrun    <= 1'b0;
            oRetryCount <= 8'd0;
        end else begin
            oTransmit <= 1'b0;
            if (iRxFlag && state != IDLE)
                oOverrun <= 1'b1;
            case (state)
                IDLE: if (iRxFlag) begin
                    oMemAddr  <= iAddr;
                    oMemWData <= iData;
                    isRead    <= iRead;
                    oTransmit <= 1'b1;
                    if (reqBad) begin
                        state       <= TX_RETRY;
                        oOutputMsg  <= mkMsg(16'hFFF3, 32'd0, iAddr, 8'hFF);
                        oRetryCount <= retryNext;
                    end else begin
                        state      <= TX_WAIT;
                        oOutputMsg <= mkMsg(16'hFFF1, 32'd0, iAddr, 8'h00);
                    end
                end
                TX_WAIT: state <= DONE_WAIT;
                DONE_WAIT: if (iTxDone) begin
                    state   <= MEM;
                    oMemReq <= 1'b1;
                    memCnt  <= 8'd0;
                end
                // ack on the last allowed cycle still wins over the timeout
                MEM: if (iMemAck) begin
                    state      <= TX_READY;
                    oMemReq    <= 1'b0;
                    oTransmit  <= 1'b1;
                    oOutputMsg <= mkMsg(16'hFFF2, isRead ? iMemRData : oMemWData, oMemAddr, 8'h00);
                end else if (memCnt == 8'(MEM_TIMEOUT - 1)) begin
                    state       <= TX_RETRY;
                    oMemReq     <= 1'b0;
                    oTransmit   <= 1'b1;
                    oOutputMsg  <= mkMsg(16'hFFF3, 32'd0, oMemAddr, 8'hFF);
                    oRetryCount <= retryNext;
                end else begin
                    memCnt <= memCnt + 8'd1;
                end
                TX_READY:   state <= DONE_READY;
                DONE_READY: if (iTxDone) state <= IDLE;
                TX_RETRY:   state <= DONE_RETRY;
                DONE_RETRY: if (iTxDone) state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memctrl_responder.sv
// tb_memctrl_responder: directed checks of the responder message flow, timeout, overrun and reset.
module tb_memctrl_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iRxFlag = 1'b0, iRead = 1'b0, iWrite = 1'b0, iError = 1'b0, iTxDone = 1'b0;
    logic [23:0] iAddr = '0;
    logic [31:0] iData = '0;
    logic        iMemAck = 1'b0;
    logic [31:0] iMemRData = '0;

    logic        oTransmit, oMemReq, oMemWe, oBusy, oOverrun;
    logic [95:0] oOutputMsg;
    logic [23:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [7:0]  oRetryCount;

    logic        tTransmit, tMemReq, tMemWe, tBusy, tOverrun;
    logic [95:0] tOutputMsg;
    logic [23:0] tMemAddr;
    logic [31:0] tMemWData;
    logic [7:0]  tRetryCount;

    int nChecks = 0;
    int nFails = 0;

    always #5 clk = ~clk;

    memctrl_responder dut (
        .clk(clk), .reset(reset), .iRxFlag(iRxFlag), .iRead(iRead), .iWrite(iWrite),
        .iAddr(iAddr), .iData(iData), .iError(iError), .iTxDone(iTxDone),
        .oTransmit(oTransmit), .oOutputMsg(oOutputMsg), .oMemReq(oMemReq), .oMemWe(oMemWe),
        .oMemAddr(oMemAddr), .oMemWData(oMemWData), .iMemAck(iMemAck), .iMemRData(iMemRData),
        .oBusy(oBusy), .oOverrun(oOverrun), .oRetryCount(oRetryCount)
    );

    memctrl_responder #(.MEM_TIMEOUT(4)) dutT (
        .clk(clk), .reset(reset), .iRxFlag(iRxFlag), .iRead(iRead), .iWrite(iWrite),
        .iAddr(iAddr), .iData(iData), .iError(iError), .iTxDone(iTxDone),
        .oTransmit(tTransmit), .oOutputMsg(tOutputMsg), .oMemReq(tMemReq), .oMemWe(tMemWe),
        .oMemAddr(tMemAddr), .oMemWData(tMemWData), .iMemAck(iMemAck), .iMemRData(iMemRData),
        .oBusy(tBusy), .oOverrun(tOverrun), .oRetryCount(tRetryCount)
    );

    function automatic logic [95:0] msg(input logic [15:0] hdr, input logic [31:0] data,
                                        input logic [23:0] addr, input logic [7:0] err);
        return {8'h0F, hdr, data, addr, err, 8'hF0};
    endfunction

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendReq(input logic rd, input logic wr, input logic [23:0] addr,
                           input logic [31:0] data, input logic err);
        iRxFlag = 1'b1; iRead = rd; iWrite = wr; iAddr = addr; iData = data; iError = err;
        tick();
        iRxFlag = 1'b0; iRead = 1'b0; iWrite = 1'b0; iError = 1'b0;
    endtask

    // iTxDone two cycles after the oTransmit cycle
    task automatic finishTx();
        tick();
        tick();
        iTxDone = 1'b1;
        tick();
        iTxDone = 1'b0;
    endtask

    task automatic memAck(input int delay, input logic [31:0] rdata);
        for (int i = 0; i < delay; i++) tick();
        iMemAck = 1'b1;
        iMemRData = rdata;
        tick();
        iMemAck = 1'b0;
    endtask

    initial begin
        int n;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("reset_msg", oOutputMsg, 96'd0);
        check("reset_ctl", {oTransmit, oMemReq, oMemWe, oBusy, oOverrun, oRetryCount}, 0);

        // good write
        sendReq(1'b0, 1'b1, 24'h00000F, 32'hF0F0F0F0, 1'b0);
        check("wr_wait_tx", oTransmit, 1);
        check("wr_wait_msg", oOutputMsg, msg(16'hFFF1, 32'd0, 24'h00000F, 8'h00));
        check("wr_busy", oBusy, 1);
        finishTx();
        check("wr_memreq", {oMemReq, oMemWe}, 2'b11);
        check("wr_memaddr", {oMemAddr, oMemWData}, {24'h00000F, 32'hF0F0F0F0});
        check("wr_wait_hold", oOutputMsg, msg(16'hFFF1, 32'd0, 24'h00000F, 8'h00));
        memAck(3, 32'h0BAD0BAD);
        check("wr_ready_tx", {oTransmit, oMemReq}, 2'b10);
        check("wr_ready_msg", oOutputMsg, msg(16'hFFF2, 32'hF0F0F0F0, 24'h00000F, 8'h00));
        tick();
        tick();
        iTxDone = 1'b1;
        check("wr_busy_before_done", oBusy, 1);
        tick();
        iTxDone = 1'b0;
        check("wr_idle", oBusy, 0);

        // good read
        sendReq(1'b1, 1'b0, 24'hFFFFFF, 32'd0, 1'b0);
        check("rd_wait_msg", oOutputMsg, msg(16'hFFF1, 32'd0, 24'hFFFFFF, 8'h00));
        finishTx();
        check("rd_memreq", {oMemReq, oMemWe}, 2'b10);
        memAck(3, 32'hABCDEFAB);
        check("rd_ready_msg", oOutputMsg, msg(16'hFFF2, 32'hABCDEFAB, 24'hFFFFFF, 8'h00));
        finishTx();
        check("rd_idle", oBusy, 0);

        // errored read, then clean resend
        sendReq(1'b1, 1'b0, 24'hFFFFFF, 32'd0, 1'b1);
        check("err_tx", {oTransmit, oMemReq}, 2'b10);
        check("err_msg", oOutputMsg, msg(16'hFFF3, 32'd0, 24'hFFFFFF, 8'hFF));
        check("err_retry", oRetryCount, 8'd1);
        finishTx();
        check("err_noreq", {oMemReq, oBusy}, 2'b00);
        sendReq(1'b1, 1'b0, 24'hFFFFFF, 32'd0, 1'b0);
        finishTx();
        memAck(2, 32'h12345678);
        check("resend_ready", oOutputMsg, msg(16'hFFF2, 32'h12345678, 24'hFFFFFF, 8'h00));
        finishTx();

        // illegal read+write
        sendReq(1'b1, 1'b1, 24'h000123, 32'hDEADBEEF, 1'b0);
        check("ill_msg", oOutputMsg, msg(16'hFFF3, 32'd0, 24'h000123, 8'hFF));
        check("ill_retry", oRetryCount, 8'd2);
        finishTx();

        // overrun during DONE_WAIT
        sendReq(1'b0, 1'b1, 24'h000ABC, 32'h11223344, 1'b0);
        tick();
        check("ovr_clear", oOverrun, 0);
        sendReq(1'b1, 1'b0, 24'h555555, 32'h99999999, 1'b0);
        check("ovr_set", oOverrun, 1);
        iTxDone = 1'b1;
        tick();
        iTxDone = 1'b0;
        check("ovr_mem", {oMemReq, oMemWe, oMemAddr, oMemWData}, {2'b11, 24'h000ABC, 32'h11223344});
        memAck(0, 32'h77777777);
        check("ovr_ready", oOutputMsg, msg(16'hFFF2, 32'h11223344, 24'h000ABC, 8'h00));
        finishTx();
        check("ovr_sticky", {oOverrun, oBusy}, 2'b10);

        // timeout on the short-timeout instance; main instance stays in MEM
        sendReq(1'b0, 1'b1, 24'h000777, 32'h0, 1'b0);
        finishTx();
        n = 0;
        while (tMemReq && n < 20) begin
            n++;
            tick();
        end
        check("to_req_cycles", n, 4);
        check("to_retry_tx", tTransmit, 1);
        check("to_retry_msg", tOutputMsg, msg(16'hFFF3, 32'd0, 24'h000777, 8'hFF));
        check("to_retry_cnt", tRetryCount, 8'd3);
        check("main_still_mem", oMemReq, 1);

        // asynchronous reset mid-cycle while in MEM
        #2 reset = 1'b1;
        #1;
        check("rst_msg", oOutputMsg, 96'd0);
        check("rst_ctl", {oTransmit, oMemReq, oMemWe, oBusy, oOverrun, oRetryCount, oMemAddr, oMemWData}, 0);
        tick();
        reset = 1'b0;
        tick();

        // post-reset write with immediate ack
        sendReq(1'b0, 1'b1, 24'h0000AA, 32'hCAFEF00D, 1'b0);
        check("pr_wait_msg", oOutputMsg, msg(16'hFFF1, 32'd0, 24'h0000AA, 8'h00));
        finishTx();
        memAck(0, 32'h0);
        check("pr_ready_msg", oOutputMsg, msg(16'hFFF2, 32'hCAFEF00D, 24'h0000AA, 8'h00));
        check("pr_retry", oRetryCount, 8'd0);
        finishTx();

        // retry counter saturation
        for (int i = 0; i < 254; i++) begin
            sendReq(1'b1, 1'b0, 24'h000001, 32'd0, 1'b1);
            finishTx();
        end
        check("sat_254", oRetryCount, 8'd254);
        sendReq(1'b1, 1'b0, 24'h000001, 32'd0, 1'b1);
        finishTx();
        check("sat_255", oRetryCount, 8'd255);
        sendReq(1'b1, 1'b0, 24'h000001, 32'd0, 1'b1);
        finishTx();
        check("sat_hold", oRetryCount, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
